// File: rtl/replica_pkg.sv
// Shared types for the replica route RAM and its stream master.
// The command, word and route-length definitions live here so every replica block agrees on them.
package replica_pkg;

    localparam int city_num = 8;
    localparam int DATA_W   = 16;

    typedef logic [DATA_W-1:0] replica_data;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        WRITE = 2'd1,
        SWAP  = 2'd2
    } replica_command;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        BURST  = 3'd2,
        FLUSH  = 3'd3,
        UNLOAD = 3'd4
    } master_state_t;

endpackage

// File: rtl/replica_stream_master_buf.sv
// Route staging buffer: DEPTH words, one write port, one registered read port.
// The read register clears on reset so the RAM-side data path starts at zero.
module replica_route_buf
    import replica_pkg::*;
#(
    parameter int DEPTH = city_num,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  replica_data   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output replica_data   rdata_o
);

    replica_data mem_q [DEPTH];
    replica_data rdata_q;

    // Storage array; contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/replica_stream_master.sv
// Host-side burst initiator for one replica route RAM: buffers a route, streams it
// into the RAM in one uninterrupted burst and optionally returns the displaced route.
module replica_stream_master
    import replica_pkg::*;
#(
    parameter int CITY_NUM = city_num,
    parameter int IDX_W    = $clog2(CITY_NUM)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  replica_command req_cmd,
    input  logic           req_swap,
    input  logic           in_valid,
    output logic           in_ready,
    input  replica_data    in_data,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output replica_data    rsp_data,
    output logic           rsp_last,
    output logic           busy,
    output replica_command ram_command,
    output replica_data    ram_prev_data,
    input  replica_data    ram_out_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CITY_NUM - 1);

    master_state_t  state_q;
    logic [IDX_W-1:0] idx_q;
    replica_command cmd_q;
    replica_command ram_command_q;
    logic           swap_q;
    logic           drive_q;

    logic             idx_last_s;
    logic [IDX_W-1:0] idx_inc_s;
    logic             buf_we_s;
    logic [IDX_W-1:0] buf_waddr_s;
    logic [IDX_W-1:0] buf_raddr_s;
    replica_data      buf_wdata_s;
    replica_data      buf_rdata_s;

    assign idx_last_s = (idx_q == LAST_IDX);
    assign idx_inc_s  = idx_last_s ? '0 : idx_q + IDX_W'(1);

    // Buffer port steering. During BURST the read runs one word ahead of the RAM
    // while the old word returning from the RAM lands in the slot read last cycle.
    always_comb begin
        buf_we_s    = 1'b0;
        buf_waddr_s = idx_q;
        buf_wdata_s = in_data;
        buf_raddr_s = '0;
        case (state_q)
            FILL: begin
                buf_we_s = in_valid;
            end
            BURST: begin
                buf_raddr_s = idx_inc_s;
                buf_we_s    = swap_q && (idx_q != '0);
                buf_waddr_s = idx_q - IDX_W'(1);
                buf_wdata_s = ram_out_data;
            end
            FLUSH: begin
                buf_we_s    = swap_q;
                buf_waddr_s = LAST_IDX;
                buf_wdata_s = ram_out_data;
            end
            UNLOAD: begin
                buf_raddr_s = rsp_ready ? idx_inc_s : idx_q;
            end
            default: begin
                buf_we_s = 1'b0;
            end
        endcase
    end

    // Burst sequencer with registered RAM command and data-enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cmd_q         <= NOP;
            swap_q        <= 1'b0;
            ram_command_q <= NOP;
            drive_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && (req_cmd != NOP)) begin
                        cmd_q   <= req_cmd;
                        swap_q  <= req_swap;
                        idx_q   <= '0;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        idx_q <= idx_inc_s;
                        if (idx_last_s) begin
                            state_q       <= BURST;
                            ram_command_q <= cmd_q;
                            drive_q       <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    ram_command_q <= NOP;
                    idx_q         <= idx_inc_s;
                    if (idx_last_s) begin
                        drive_q <= 1'b0;
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    idx_q   <= '0;
                    state_q <= swap_q ? UNLOAD : IDLE;
                end
                UNLOAD: begin
                    if (rsp_ready) begin
                        idx_q <= idx_inc_s;
                        if (idx_last_s) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    idx_q         <= '0;
                    ram_command_q <= NOP;
                    drive_q       <= 1'b0;
                end
            endcase
        end
    end

    replica_route_buf #(
        .DEPTH (CITY_NUM),
        .AW    (IDX_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .we_i    (buf_we_s),
        .waddr_i (buf_waddr_s),
        .wdata_i (buf_wdata_s),
        .raddr_i (buf_raddr_s),
        .rdata_o (buf_rdata_s)
    );

    assign req_ready     = (state_q == IDLE);
    assign in_ready      = (state_q == FILL);
    assign rsp_valid     = (state_q == UNLOAD);
    assign rsp_last      = (state_q == UNLOAD) && idx_last_s;
    assign busy          = (state_q != IDLE);
    assign rsp_data      = buf_rdata_s;
    assign ram_command   = ram_command_q;
    assign ram_prev_data = drive_q ? buf_rdata_s : '0;

endmodule

// File: tb/tb_replica_stream_master.sv
// Directed bench for replica_stream_master driving a behavioural replica route RAM.
module tb_replica_stream_master;
    import replica_pkg::*;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    replica_command req_cmd;
    logic           req_swap;
    logic           in_valid;
    logic           in_ready;
    replica_data    in_data;
    logic           rsp_valid;
    logic           rsp_ready;
    replica_data    rsp_data;
    logic           rsp_last;
    logic           busy;
    replica_command ram_command;
    replica_data    ram_prev_data;
    replica_data    ram_out_data;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    replica_stream_master #(.CITY_NUM(N)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cmd       (req_cmd),
        .req_swap      (req_swap),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_last      (rsp_last),
        .busy          (busy),
        .ram_command   (ram_command),
        .ram_prev_data (ram_prev_data),
        .ram_out_data  (ram_out_data)
    );

    // Replica route RAM: writes N words from the command cycle, old word i out at cycle i+1.
    replica_data ram_mem [N];
    logic [2:0]  ram_cnt;
    logic        ram_act;

    always @(posedge clk) begin
        if (reset) begin
            ram_act      <= 1'b0;
            ram_cnt      <= 3'd0;
            ram_out_data <= '0;
        end else if (ram_command != NOP) begin
            ram_out_data <= ram_mem[0];
            ram_mem[0]   <= ram_prev_data;
            ram_cnt      <= 3'd1;
            ram_act      <= 1'b1;
        end else if (ram_act) begin
            ram_out_data     <= ram_mem[ram_cnt];
            ram_mem[ram_cnt] <= ram_prev_data;
            if (ram_cnt == 3'd7) begin
                ram_act <= 1'b0;
                ram_cnt <= 3'd0;
            end else begin
                ram_cnt <= ram_cnt + 3'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input replica_command cmd, input logic swap);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_swap  = swap;
        check("req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_cmd   = NOP;
    endtask

    task automatic fill(input int base, input bit gaps);
        for (int i = 0; i < N; i++) begin
            check("fill_in_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = replica_data'(base + i);
            tick();
            if (gaps && i < N - 1) begin
                in_valid = 1'b0;
                in_data  = 16'hdead;
                check("gap_no_cmd", 32'(ram_command), 32'(NOP));
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_burst(input int base, input replica_command cmd);
        for (int c = 0; c < N; c++) begin
            check("burst_cmd", 32'(ram_command), (c == 0) ? 32'(cmd) : 32'(NOP));
            check("burst_data", 32'(ram_prev_data), 32'(base + c));
            check("burst_busy", 32'(busy), 32'd1);
            check("burst_rsp_valid", 32'(rsp_valid), 32'd0);
            tick();
        end
        check("flush_cmd", 32'(ram_command), 32'(NOP));
        check("flush_data", 32'(ram_prev_data), 32'd0);
        check("flush_busy", 32'(busy), 32'd1);
        check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
    endtask

    task automatic unload(input int base, input bit stall);
        int got = 0;
        int stall_left = stall ? 3 : 0;
        for (int cyc = 0; cyc < N + 8 && got < N; cyc++) begin
            rsp_ready = (got == 3 && stall_left > 0) ? 1'b0 : 1'b1;
            check("rsp_valid", 32'(rsp_valid), 32'd1);
            check("rsp_data", 32'(rsp_data), 32'(base + got));
            check("rsp_last", 32'(rsp_last), (got == N - 1) ? 32'd1 : 32'd0);
            if (rsp_ready) begin
                got++;
            end else begin
                stall_left--;
            end
            tick();
        end
        rsp_ready = 1'b0;
        check("rsp_count", 32'(got), 32'(N));
        check("post_unload_valid", 32'(rsp_valid), 32'd0);
        check("post_unload_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_ram(input int base);
        for (int i = 0; i < N; i++) begin
            check("ram_word", 32'(ram_mem[i]), 32'(base + i));
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_cmd   = NOP;
        req_swap  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_last", 32'(rsp_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd", 32'(ram_command), 32'(NOP));
        check("rst_prev_data", 32'(ram_prev_data), 32'd0);
        reset = 1'b0;
        tick();

        // Write only: words 1..8, old route discarded.
        request(WRITE, 1'b0);
        check("fill_busy", 32'(busy), 32'd1);
        fill(1, 1'b0);
        run_burst(1, WRITE);
        check("wr_busy_drop", 32'(busy), 32'd0);
        check("wr_no_rsp", 32'(rsp_valid), 32'd0);
        check_ram(1);

        // Swap: 11..18 in, 1..8 back.
        request(SWAP, 1'b1);
        fill(11, 1'b0);
        run_burst(11, SWAP);
        unload(1, 1'b0);
        check_ram(11);

        // Backpressure on both sides.
        request(SWAP, 1'b1);
        fill(31, 1'b1);
        run_burst(31, SWAP);
        unload(11, 1'b1);
        check_ram(31);

        // NOP request is accepted and dropped.
        req_valid = 1'b1;
        req_cmd   = NOP;
        check("nop_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check("nop_busy", 32'(busy), 32'd0);
        check("nop_in_ready", 32'(in_ready), 32'd0);
        check("nop_cmd", 32'(ram_command), 32'(NOP));
        tick();
        check("nop_busy_later", 32'(busy), 32'd0);
        check("nop_in_ready_later", 32'(in_ready), 32'd0);

        // Reset at burst cycle 4, then a clean write of 21..28.
        request(SWAP, 1'b1);
        fill(41, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("pre_rst_data", 32'(ram_prev_data), 32'd45);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_cmd", 32'(ram_command), 32'(NOP));
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_prev_data", 32'(ram_prev_data), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        request(WRITE, 1'b0);
        fill(21, 1'b0);
        run_burst(21, WRITE);
        check("post_rst_busy", 32'(busy), 32'd0);
        check_ram(21);

        // Back-to-back swaps: second request held while the first unloads.
        request(SWAP, 1'b1);
        fill(51, 1'b0);
        run_burst(51, SWAP);
        req_valid = 1'b1;
        req_cmd   = SWAP;
        req_swap  = 1'b1;
        check("b2b_held", 32'(req_ready), 32'd0);
        unload(21, 1'b0);
        check("b2b_accept", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        req_cmd   = NOP;
        check("b2b_fill", 32'(in_ready), 32'd1);
        check("b2b_no_cmd", 32'(ram_command), 32'(NOP));
        fill(61, 1'b0);
        run_burst(61, SWAP);
        unload(51, 1'b0);
        check_ram(61);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
